// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count, almost flags,
// sticky error flags and synchronous flush. Define FIFO_FWFT_EN for first-word-fall-through. Rev 1.0
`default_nettype none

module fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR      = 4,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr_enb,
  input  logic             rd_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ADDR:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [ADDR:0] C_DEPTH  = (ADDR+1)'(DEPTH);
  localparam logic [ADDR:0] C_AF_LVL = (ADDR+1)'(DEPTH - AF_MARGIN);
  localparam logic [ADDR:0] C_AE_LVL = (ADDR+1)'(AE_MARGIN);

  if (DEPTH != (1 << ADDR)) begin : g_bad_depth
    $error("fifo_param: DEPTH must equal 2**ADDR");
  end
  if (AF_MARGIN >= DEPTH) begin : g_bad_af
    $error("fifo_param: AF_MARGIN must be less than DEPTH");
  end
  if (AE_MARGIN >= DEPTH) begin : g_bad_ae
    $error("fifo_param: AE_MARGIN must be less than DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc, rd_acc;

  assign full         = (count_q == C_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= C_AF_LVL);
  assign almost_empty = (count_q <= C_AE_LVL);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Flush wins over both requests, so it also masks the accept strobes.
  assign wr_acc = wr_enb & ~full  & ~flush;
  assign rd_acc = rd_enb & ~empty & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + (ADDR+1)'(1);
        2'b01:   count_d = count_q - (ADDR+1)'(1);
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q  | (wr_enb & full);
      underflow_d = underflow_q | (rd_enb & empty);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

`ifdef FIFO_FWFT_EN
  assign data_out = empty ? '0 : mem_q[rd_ptr_q];
`else
  logic [WIDTH-1:0] data_out_q, data_out_d;

  assign data_out_d = rd_acc ? mem_q[rd_ptr_q] : data_out_q;
  assign data_out   = data_out_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) data_out_q <= '0;
    else       data_out_q <= data_out_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_param.sv
// tb_fifo_param: scoreboard-driven bench for fifo_param, default parameters and registered read.
`default_nettype none

module tb_fifo_param;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int ADDR  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             wr_enb = 1'b0;
  logic             rd_enb = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             full, empty, almost_full, almost_empty;
  logic [ADDR:0]    count;
  logic             overflow, underflow;

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] sb[$];
  logic [WIDTH-1:0] last_out = '0;
  logic [WIDTH-1:0] exp_d;

  fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .flush(flush), .data_in(data_in), .wr_enb(wr_enb), .rd_enb(rd_enb),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {5'd0, 6'b101000}) begin
      miscompares++;
      $display("FAIL reset_flags: count=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want 0 1 0 1 0 0 0",
               count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
    vectors++;
    if (data_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: data_out=%h want 00", data_out);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      wr_enb = 1'b1; data_in = WIDTH'(i); sb.push_back(WIDTH'(i));
      step();
      vectors++;
      if (count !== 5'(i) || full !== (i == DEPTH) || almost_full !== (i >= DEPTH - 2) ||
          almost_empty !== (i <= 2) || empty !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_flags[%0d]: count=%0d f=%b af=%b ae=%b e=%b", i, count, full, almost_full,
                 almost_empty, empty);
      end
    end
    wr_enb = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_enb = 1'b1;
      step();
      exp_d = sb.pop_front(); last_out = exp_d;
      vectors++;
      if (data_out !== exp_d || count !== 5'(DEPTH - 1 - i) || empty !== (i == DEPTH - 1)) begin
        miscompares++;
        $display("FAIL drain[%0d]: data_out=%h count=%0d e=%b, want %h %0d %b", i, data_out, count, empty,
                 exp_d, DEPTH - 1 - i, i == DEPTH - 1);
      end
    end
    rd_enb = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      wr_enb = 1'b1; data_in = 8'h20 + 8'(i); sb.push_back(8'h20 + 8'(i));
      step();
    end
    data_in = 8'hAA;
    step();
    wr_enb = 1'b0;
    vectors++;
    if (overflow !== 1'b1 || count !== 5'd16 || underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_set: ov=%b count=%0d un=%b, want 1 16 0", overflow, count, underflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_enb = 1'b1;
      step();
      exp_d = sb.pop_front(); last_out = exp_d;
      vectors++;
      if (data_out !== exp_d) begin
        miscompares++;
        $display("FAIL overflow_drain[%0d]: data_out=%h want %h", i, data_out, exp_d);
      end
    end
    rd_enb = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || data_out !== last_out) begin
      miscompares++;
      $display("FAIL overflow_flush: ov=%b count=%0d e=%b data_out=%h, want 0 0 1 %h", overflow, count,
               empty, data_out, last_out);
    end
  endtask

  task automatic test_underflow_simul();
    wr_enb = 1'b1; rd_enb = 1'b1; data_in = 8'h3C; sb.push_back(8'h3C);
    step();
    wr_enb = 1'b0;
    vectors++;
    if (underflow !== 1'b1 || count !== 5'd1 || data_out !== last_out || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_set: un=%b count=%0d data_out=%h ov=%b, want 1 1 %h 0", underflow, count,
               data_out, overflow, last_out);
    end
    step();
    rd_enb = 1'b0;
    exp_d = sb.pop_front(); last_out = exp_d;
    vectors++;
    if (data_out !== exp_d || count !== 5'd0 || underflow !== 1'b1) begin
      miscompares++;
      $display("FAIL underflow_read: data_out=%h count=%0d un=%b, want %h 0 1", data_out, count, underflow,
               exp_d);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    vectors++;
    if (underflow !== 1'b0) begin
      miscompares++;
      $display("FAIL underflow_flush: un=%b want 0", underflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr_enb = 1'b1; data_in = 8'h40 + 8'(i); sb.push_back(8'h40 + 8'(i));
      step();
    end
    for (int i = 0; i < 20; i++) begin
      wr_enb = 1'b1; rd_enb = 1'b1; data_in = 8'h80 + 8'(i); sb.push_back(8'h80 + 8'(i));
      step();
      exp_d = sb.pop_front(); last_out = exp_d;
      vectors++;
      if (data_out !== exp_d || count !== 5'd8) begin
        miscompares++;
        $display("FAIL b2b[%0d]: data_out=%h count=%0d, want %h 8", i, data_out, count, exp_d);
      end
    end
    wr_enb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_enb = 1'b1;
      step();
      exp_d = sb.pop_front(); last_out = exp_d;
      vectors++;
      if (data_out !== exp_d) begin
        miscompares++;
        $display("FAIL b2b_drain[%0d]: data_out=%h want %h", i, data_out, exp_d);
      end
    end
    rd_enb = 1'b0;
  endtask

  task automatic test_flush_priority();
    for (int i = 0; i < 6; i++) begin
      wr_enb = 1'b1; data_in = 8'hC0 + 8'(i);
      step();
    end
    flush = 1'b1; wr_enb = 1'b1; rd_enb = 1'b1; data_in = 8'hEE;
    step();
    flush = 1'b0; wr_enb = 1'b0; rd_enb = 1'b0;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || data_out !== last_out) begin
      miscompares++;
      $display("FAIL flush_priority: count=%0d e=%b ov=%b un=%b data_out=%h, want 0 1 0 0 %h", count, empty,
               overflow, underflow, data_out, last_out);
    end
    // A write after flush must land in the first slot and be read back alone.
    wr_enb = 1'b1; data_in = 8'h5A;
    step();
    wr_enb = 1'b0; rd_enb = 1'b1;
    step();
    rd_enb = 1'b0; last_out = 8'h5A;
    vectors++;
    if (data_out !== 8'h5A || count !== 5'd0) begin
      miscompares++;
      $display("FAIL flush_then_rw: data_out=%h count=%0d, want 5a 0", data_out, count);
    end
  endtask

  task automatic test_reset_midfill();
    for (int i = 0; i < 5; i++) begin
      wr_enb = 1'b1; data_in = 8'h11 * 8'(i + 1);
      step();
    end
    wr_enb = 1'b0; rd_enb = 1'b1;
    step();
    rd_enb = 1'b0;
    vectors++;
    if (data_out !== 8'h11 || count !== 5'd4) begin
      miscompares++;
      $display("FAIL midfill_pre: data_out=%h count=%0d, want 11 4", data_out, count);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1 || data_out !== 8'h00 || almost_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_reset: count=%0d e=%b data_out=%h ae=%b, want 0 1 00 1", count, empty,
               data_out, almost_empty);
    end
    step();
    reset = 1'b0;
    step();
    vectors++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_after: count=%0d e=%b, want 0 1", count, empty);
    end
  endtask

  initial begin
    step();
    step();
    test_reset();
    reset = 1'b0;
    step();
    test_fill_drain();
    test_overflow();
    test_underflow_simul();
    test_back_to_back();
    test_flush_priority();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
